// File: rtl/combo_if.sv
// Bus bundle for the combo decision block: five function inputs, the counter
// clear, and the combinational and registered observation outputs.
//   master : drives a..e and clr, observes z, z_q, z_rise, z_cnt
//   slave  : the combo block itself
interface combo_if #(
    parameter int unsigned CNT_W = 8
);
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             e;
    logic             clr;
    logic             z;
    logic             z_q;
    logic             z_rise;
    logic [CNT_W-1:0] z_cnt;

    modport master (
        output a, b, c, d, e, clr,
        input  z, z_q, z_rise, z_cnt
    );

    modport slave (
        input  a, b, c, d, e, clr,
        output z, z_q, z_rise, z_cnt
    );
endinterface

// File: rtl/combo.sv
// Five-input Boolean decision block with a registered observation path.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset of the registered path
//   bus.a..e   : function inputs, a is the MSB of the 5-bit code
//   bus.clr    : synchronous clear of z_cnt, wins over an increment
//   bus.z      : combinational result (a&b) | (c&d&~e) | (~a&~b&e)
//   bus.z_q    : z registered on clk
//   bus.z_rise : one-cycle pulse, aligned with z_q, on each 0->1 of z_q
//   bus.z_cnt  : saturating count of z_rise pulses
module combo #(
    parameter int unsigned CNT_W = 8
) (
    input  logic   clk,
    input  logic   rst,
    combo_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic rise_c;

    // Decision function; no dependence on clk, rst or clr.
    assign bus.z = (bus.a & bus.b)
                 | (bus.c & bus.d & ~bus.e)
                 | (~bus.a & ~bus.b & bus.e);

    // The current z_q is the "previous" sample for the value about to be
    // registered, so the edge pulse lands in the same cycle as the new z_q.
    assign rise_c = bus.z & ~bus.z_q;

    // Registered sample, edge flag and saturating edge counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.z_q    <= 1'b0;
            bus.z_rise <= 1'b0;
            bus.z_cnt  <= '0;
        end else begin
            bus.z_q    <= bus.z;
            bus.z_rise <= rise_c;
            if (bus.clr) begin
                bus.z_cnt <= '0;
            end else if (rise_c && (bus.z_cnt != CNT_MAX)) begin
                bus.z_cnt <= bus.z_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_combo.sv
// Directed bench for combo: a default-width instance and a 2-bit counter
// instance driven with the same inputs.
module tb_combo;
    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst    = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    combo_if #(.CNT_W(8)) bus8 ();
    combo_if #(.CNT_W(2)) bus2 ();

    combo #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    combo #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = clk_en ? ~clk : 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_i(input logic [4:0] i);
        {bus8.a, bus8.b, bus8.c, bus8.d, bus8.e} = i;
        {bus2.a, bus2.b, bus2.c, bus2.d, bus2.e} = i;
    endtask

    task automatic set_clr(input logic v);
        bus8.clr = v;
        bus2.clr = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] zmask;
        int          ones;
        int          rises;
        int          exp2;
        logic        prev_z;

        zmask = 32'hFF40_40EA;   // codes 1,3,5,6,7,14,22,24..31
        set_i(5'd0);
        set_clr(1'b0);

        // Reset state, no clock running.
        #1 rst = 1'b1;
        #2;
        chk("rst_z_q",    32'(bus8.z_q),    32'd0);
        chk("rst_z_rise", 32'(bus8.z_rise), 32'd0);
        chk("rst_z_cnt8", 32'(bus8.z_cnt),  32'd0);
        chk("rst_z_cnt2", 32'(bus2.z_cnt),  32'd0);

        // Exhaustive combinational sweep, clock stopped.
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            set_i(5'(i));
            #10;
            chk($sformatf("comb_z_%0d", i), 32'(bus8.z), 32'(zmask[i]));
            if (bus8.z === 1'b1) ones++;
        end
        chk("comb_ones", 32'(ones), 32'd15);

        // Spot checks.
        set_i(5'd0);  #10; chk("spot_0",  32'(bus8.z), 32'd0);
        set_i(5'd6);  #10; chk("spot_6",  32'(bus8.z), 32'd1);
        set_i(5'd7);  #10; chk("spot_7",  32'(bus8.z), 32'd1);
        set_i(5'd15); #10; chk("spot_15", 32'(bus8.z), 32'd0);
        set_i(5'd24); #10; chk("spot_24", 32'(bus8.z), 32'd1);

        // Registered latency: i = 0,1,0,1 on successive edges.
        set_i(5'd0);
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("lat0_z_q",    32'(bus8.z_q),    32'd0);
        chk("lat0_z_rise", 32'(bus8.z_rise), 32'd0);
        set_i(5'd1);
        tick();
        chk("lat1_z_q",    32'(bus8.z_q),    32'd1);
        chk("lat1_z_rise", 32'(bus8.z_rise), 32'd1);
        chk("lat1_z_cnt",  32'(bus8.z_cnt),  32'd1);
        set_i(5'd0);
        tick();
        chk("lat2_z_q",    32'(bus8.z_q),    32'd0);
        chk("lat2_z_rise", 32'(bus8.z_rise), 32'd0);
        set_i(5'd1);
        tick();
        chk("lat3_z_q",    32'(bus8.z_q),    32'd1);
        chk("lat3_z_rise", 32'(bus8.z_rise), 32'd1);
        chk("lat3_z_cnt",  32'(bus8.z_cnt),  32'd2);
        tick();
        chk("lat4_z_rise", 32'(bus8.z_rise), 32'd0);
        chk("lat4_z_cnt",  32'(bus8.z_cnt),  32'd2);

        // Build up to z_cnt=5 with z_q=1, then reset between edges.
        for (int k = 0; k < 3; k++) begin
            set_i(5'd0); tick();
            set_i(5'd1); tick();
        end
        chk("pre_rst_cnt8", 32'(bus8.z_cnt), 32'd5);
        chk("pre_rst_cnt2", 32'(bus2.z_cnt), 32'd3);
        chk("pre_rst_z_q",  32'(bus8.z_q),   32'd1);
        set_i(5'd24);
        #2 rst = 1'b1;
        #1;
        chk("arst_z_q",    32'(bus8.z_q),    32'd0);
        chk("arst_z_rise", 32'(bus8.z_rise), 32'd0);
        chk("arst_z_cnt",  32'(bus8.z_cnt),  32'd0);
        chk("arst_z",      32'(bus8.z),      32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rel_z_q",    32'(bus8.z_q),    32'd1);
        chk("rel_z_rise", 32'(bus8.z_rise), 32'd1);
        chk("rel_z_cnt8", 32'(bus8.z_cnt),  32'd1);
        chk("rel_z_cnt2", 32'(bus2.z_cnt),  32'd1);

        // Saturation on the 2-bit counter over 5 further rising edges.
        exp2 = 1;
        for (int k = 0; k < 5; k++) begin
            set_i(5'd0); tick();
            set_i(5'd1); tick();
            if (exp2 < 3) exp2++;
            chk($sformatf("sat_cnt2_%0d", k), 32'(bus2.z_cnt), 32'(exp2));
        end
        chk("sat_cnt8", 32'(bus8.z_cnt), 32'd6);

        // Clear coincident with a rising edge of z.
        set_i(5'd0); tick();
        set_i(5'd1);
        set_clr(1'b1);
        tick();
        set_clr(1'b0);
        chk("clr_z_rise", 32'(bus2.z_rise), 32'd1);
        chk("clr_cnt2",   32'(bus2.z_cnt),  32'd0);
        chk("clr_cnt8",   32'(bus8.z_cnt),  32'd0);

        // Clocked full sweep from a fresh reset.
        set_i(5'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rises  = 0;
        prev_z = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_i(5'(i));
            tick();
            chk($sformatf("sweep_z_q_%0d", i), 32'(bus8.z_q), 32'(zmask[i]));
            chk($sformatf("sweep_rise_%0d", i), 32'(bus8.z_rise),
                32'(zmask[i] & ~prev_z));
            prev_z = zmask[i];
            if (bus8.z_rise === 1'b1) rises++;
        end
        chk("sweep_rises",    32'(rises),        32'd6);
        chk("sweep_cnt8",     32'(bus8.z_cnt),   32'd6);
        chk("sweep_cnt2",     32'(bus2.z_cnt),   32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
